// File: rtl/atu_pkg.sv
// Shared types and constants for the antenna tuner sequence controller.
package atu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_REQ      = 3'd1,
      ST_WAIT_ACK = 3'd2,
      ST_TUNE     = 3'd3,
      ST_RELEASE  = 3'd4
   } atu_state_e;

   localparam logic [1:0] RES_NONE    = 2'd0;
   localparam logic [1:0] RES_OK      = 2'd1;
   localparam logic [1:0] RES_ACK_TO  = 2'd2;
   localparam logic [1:0] RES_TUNE_TO = 2'd3;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/atu_debounce.sv
// Two-flop synchronizer plus tick-sampled debouncer for slow external contact lines.
module atu_debounce
   import atu_pkg::*;
#(
   parameter int unsigned DEB_MS = 4,
   parameter bit          INVERT = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_i,
   input  logic raw_i,
   output logic level_o
);

   localparam int unsigned CW = cnt_width(DEB_MS);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          sample;

   assign sample  = sync2_q ^ INVERT;
   assign level_o = level_q;

   // Only an unbroken run of disagreeing tick samples flips the level.
   always_comb begin
      level_d = level_q;
      cnt_d   = cnt_q;
      if (tick_i) begin
         if (sample == level_q) begin
            cnt_d = '0;
         end else if (32'(cnt_q) + 32'd1 >= DEB_MS) begin
            level_d = sample;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= INVERT;
         sync2_q <= INVERT;
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: rtl/atu_tune_ctrl.sv
// Request/acknowledge sequencer for an AH-4 style external antenna tuner.
module atu_tune_ctrl
   import atu_pkg::*;
#(
   parameter int unsigned CYCLES_PER_MS  = 76800,
   parameter int unsigned REQ_MS         = 500,
   parameter int unsigned ACK_TIMEOUT_MS = 1000,
   parameter int unsigned TUNE_MAX_MS    = 15000,
   parameter int unsigned DEB_MS         = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic       abort_i,
   input  logic       atu_ack_raw_i,
   output logic       atu_req_o,
   output logic       tune_tx_req_o,
   output logic       busy_o,
   output logic [1:0] result_o,
   output logic       result_stb_o,
   output logic [2:0] state_o
);

   localparam int unsigned PRE_W = cnt_width(CYCLES_PER_MS);
   localparam int unsigned MS_W  = cnt_width(max3(REQ_MS, ACK_TIMEOUT_MS, TUNE_MAX_MS));

   atu_state_e       state_q;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [PRE_W-1:0] free_q, free_d;
   logic [MS_W-1:0]  ms_q, ms_d;
   logic             tick, free_tick, ack;
   logic             atu_req_q, tune_q, busy_q, stb_q;
   logic [1:0]       result_q;

   assign tick      = 32'(pre_q) + 32'd1 >= CYCLES_PER_MS;
   assign free_tick = 32'(free_q) + 32'd1 >= CYCLES_PER_MS;
   assign pre_d     = tick ? '0 : pre_q + 1'b1;
   assign free_d    = free_tick ? '0 : free_q + 1'b1;
   assign ms_d      = ms_q + MS_W'(tick);

   function automatic logic elapsed(input logic [MS_W-1:0] ms, input int unsigned lim);
      return 32'(ms) >= lim;
   endfunction

   // The debouncer needs an unbroken tick stream, so it gets its own prescaler.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) free_q <= '0;
      else     free_q <= free_d;
   end

   atu_debounce #(
      .DEB_MS (DEB_MS),
      .INVERT (1'b1)
   ) u_ack_deb (
      .clk     (clk),
      .rst     (rst),
      .tick_i  (free_tick),
      .raw_i   (atu_ack_raw_i),
      .level_o (ack)
   );

   // start_i/abort_i are single-cycle command strobes with no back-pressure;
   // abort_i outranks start_i, and ack outranks any timeout on the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         pre_q     <= '0;
         ms_q      <= '0;
         atu_req_q <= 1'b0;
         tune_q    <= 1'b0;
         busy_q    <= 1'b0;
         result_q  <= RES_NONE;
         stb_q     <= 1'b0;
      end else begin
         pre_q <= pre_d;
         ms_q  <= ms_d;
         stb_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               pre_q <= '0;
               ms_q  <= '0;
               if (start_i && !abort_i) begin
                  state_q   <= ST_REQ;
                  atu_req_q <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            ST_REQ: begin
               if (abort_i) begin
                  state_q   <= ST_IDLE;
                  atu_req_q <= 1'b0;
                  busy_q    <= 1'b0;
                  result_q  <= RES_TUNE_TO;
                  stb_q     <= 1'b1;
               end else if (elapsed(ms_d, REQ_MS)) begin
                  state_q   <= ST_WAIT_ACK;
                  atu_req_q <= 1'b0;
                  pre_q     <= '0;
                  ms_q      <= '0;
               end
            end
            ST_WAIT_ACK: begin
               if (abort_i) begin
                  state_q  <= ST_IDLE;
                  busy_q   <= 1'b0;
                  result_q <= RES_TUNE_TO;
                  stb_q    <= 1'b1;
               end else if (ack) begin
                  state_q <= ST_TUNE;
                  tune_q  <= 1'b1;
                  pre_q   <= '0;
                  ms_q    <= '0;
               end else if (elapsed(ms_d, ACK_TIMEOUT_MS)) begin
                  state_q  <= ST_IDLE;
                  busy_q   <= 1'b0;
                  result_q <= RES_ACK_TO;
                  stb_q    <= 1'b1;
               end
            end
            ST_TUNE: begin
               if (abort_i || !ack || elapsed(ms_d, TUNE_MAX_MS)) begin
                  state_q  <= ST_RELEASE;
                  tune_q   <= 1'b0;
                  result_q <= (!abort_i && !ack) ? RES_OK : RES_TUNE_TO;
                  stb_q    <= 1'b1;
                  pre_q    <= '0;
                  ms_q     <= '0;
               end
            end
            ST_RELEASE: begin
               if (elapsed(ms_d, 1)) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  pre_q   <= '0;
                  ms_q    <= '0;
               end
            end
            default: begin
               state_q   <= ST_IDLE;
               atu_req_q <= 1'b0;
               tune_q    <= 1'b0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

   assign atu_req_o     = atu_req_q;
   assign tune_tx_req_o = tune_q;
   assign busy_o        = busy_q;
   assign result_o      = result_q;
   assign result_stb_o  = stb_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_atu_tune_ctrl.sv
// Directed bench for atu_tune_ctrl with scaled-down timing parameters.
module tb_atu_tune_ctrl;

   localparam int unsigned C_MS = 10;

   logic       clk;
   logic       rst;
   logic       start_i;
   logic       abort_i;
   logic       atu_ack_raw_i;
   logic       atu_req_o;
   logic       tune_tx_req_o;
   logic       busy_o;
   logic [1:0] result_o;
   logic       result_stb_o;
   logic [2:0] state_o;

   int checks = 0;
   int errors = 0;
   logic [1:0] exp_q[$];

   atu_tune_ctrl #(
      .CYCLES_PER_MS  (C_MS),
      .REQ_MS         (5),
      .ACK_TIMEOUT_MS (8),
      .TUNE_MAX_MS    (20),
      .DEB_MS         (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .abort_i       (abort_i),
      .atu_ack_raw_i (atu_ack_raw_i),
      .atu_req_o     (atu_req_o),
      .tune_tx_req_o (tune_tx_req_o),
      .busy_o        (busy_o),
      .result_o      (result_o),
      .result_stb_o  (result_stb_o),
      .state_o       (state_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // drivers
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
   endtask

   task automatic count_req(output int n);
      n = 0;
      for (int i = 0; i < 100 && atu_req_o; i++) begin
         n++;
         step();
      end
   endtask

   task automatic wait_done(input int limit, output int at, output bit tune_seen);
      at = -1;
      tune_seen = 1'b0;
      for (int i = 1; i <= limit; i++) begin
         step();
         if (tune_tx_req_o || state_o == 3'd3) tune_seen = 1'b1;
         if (result_stb_o) begin
            at = i;
            break;
         end
      end
   endtask

   task automatic run_nominal(input string tag);
      int n, rise_at, fall_at, busy_at, stb_n, stb_at;
      exp_q.push_back(2'd1);
      pulse_start();
      check({tag, "_req_rise"}, atu_req_o, 1);
      check({tag, "_state_req"}, state_o, 3'd1);
      count_req(n);
      check({tag, "_req_width"}, n, 50);
      repeat (30) step();
      atu_ack_raw_i = 1'b0;
      rise_at = -1; fall_at = -1; busy_at = -1; stb_n = 0; stb_at = -1;
      for (int i = 1; i <= 200; i++) begin
         step();
         if (tune_tx_req_o && rise_at < 0) rise_at = i;
         if (!tune_tx_req_o && rise_at >= 0 && fall_at < 0) fall_at = i;
         if (!busy_o && busy_at < 0) busy_at = i;
         if (result_stb_o) begin
            stb_n++;
            stb_at = i;
         end
         if (i == 100) atu_ack_raw_i = 1'b1;
      end
      check({tag, "_tune_rise_window"}, (rise_at >= 14 && rise_at <= 23), 1);
      check({tag, "_tune_width"}, fall_at - rise_at, 100);
      check({tag, "_busy_tail"}, busy_at - fall_at, 10);
      check({tag, "_stb_count"}, stb_n, 1);
      check({tag, "_stb_at_fall"}, stb_at - fall_at, 0);
      check({tag, "_result"}, result_o, 2'd1);
   endtask

   // scoreboard: every strobe must match the next expected completion code
   always @(negedge clk) begin
      if (!rst && result_stb_o) begin
         check("stb_pending", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) check("stb_result", result_o, exp_q.pop_front());
      end
   end

   initial begin
      int  n, at;
      bit  ts, req_seen, stb_seen;
      rst = 1'b1;
      start_i = 1'b0;
      abort_i = 1'b0;
      atu_ack_raw_i = 1'b1;
      repeat (3) step();
      check("rst_atu_req", atu_req_o, 0);
      check("rst_tune", tune_tx_req_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_result", result_o, 2'd0);
      check("rst_state", state_o, 3'd0);
      rst = 1'b0;
      repeat (5) step();

      run_nominal("nom1");
      repeat (5) step();

      // stuck tuner: ack held active the whole time
      atu_ack_raw_i = 1'b0;
      repeat (40) step();
      exp_q.push_back(2'd3);
      pulse_start();
      count_req(n);
      check("stuck_req_width", n, 50);
      step();
      check("stuck_tune_rise", tune_tx_req_o, 1);
      n = 0;
      while (tune_tx_req_o && n < 300) begin
         n++;
         step();
      end
      check("stuck_tune_width", n, 200);
      check("stuck_stb", result_stb_o, 1);
      check("stuck_result", result_o, 2'd3);
      check("stuck_release_busy", busy_o, 1);
      atu_ack_raw_i = 1'b1;
      repeat (40) step();
      check("stuck_idle", busy_o, 0);

      // no ack
      exp_q.push_back(2'd2);
      pulse_start();
      count_req(n);
      check("noack_req_width", n, 50);
      wait_done(120, at, ts);
      check("noack_timeout_at", at, 80);
      check("noack_no_tune", ts, 0);
      check("noack_result", result_o, 2'd2);
      check("noack_busy", busy_o, 0);
      repeat (5) step();

      // abort during REQ
      exp_q.push_back(2'd3);
      pulse_start();
      repeat (20) step();
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      check("abort_req_busy", busy_o, 0);
      check("abort_req_atu_req", atu_req_o, 0);
      check("abort_req_result", result_o, 2'd3);
      check("abort_req_stb", result_stb_o, 1);
      step();
      check("abort_req_stb_one_cycle", result_stb_o, 0);

      // 1 ms glitches during WAIT_ACK never qualify
      exp_q.push_back(2'd2);
      pulse_start();
      count_req(n);
      at = -1;
      ts = 1'b0;
      for (int i = 1; i <= 120; i++) begin
         step();
         if (tune_tx_req_o || state_o == 3'd3) ts = 1'b1;
         if (result_stb_o) begin
            at = i;
            break;
         end
         atu_ack_raw_i = ((i % 30) >= 20) ? 1'b0 : 1'b1;
      end
      atu_ack_raw_i = 1'b1;
      check("glitch_timeout_at", at, 80);
      check("glitch_no_tune", ts, 0);
      check("glitch_result", result_o, 2'd2);
      repeat (40) step();

      // abort 7 ms into TUNE, with a stray start in between
      atu_ack_raw_i = 1'b0;
      repeat (40) step();
      exp_q.push_back(2'd3);
      pulse_start();
      count_req(n);
      step();
      check("abort_tune_rise", tune_tx_req_o, 1);
      req_seen = 1'b0;
      stb_seen = 1'b0;
      for (int i = 1; i <= 70; i++) begin
         step();
         if (atu_req_o) req_seen = 1'b1;
         if (result_stb_o) stb_seen = 1'b1;
         start_i = (i == 30);
      end
      check("tune_start_ignored", req_seen, 0);
      check("tune_no_early_stb", stb_seen, 0);
      check("tune_state_held", state_o, 3'd3);
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      check("abort_tune_fall", tune_tx_req_o, 0);
      check("abort_tune_result", result_o, 2'd3);
      check("abort_tune_stb", result_stb_o, 1);
      n = 0;
      while (busy_o && n < 50) begin
         n++;
         step();
      end
      check("abort_release_len", n, 10);
      atu_ack_raw_i = 1'b1;
      repeat (40) step();

      // start and abort together in IDLE
      start_i = 1'b1;
      abort_i = 1'b1;
      step();
      start_i = 1'b0;
      abort_i = 1'b0;
      check("conflict_busy", busy_o, 0);
      check("conflict_atu_req", atu_req_o, 0);
      check("conflict_stb", result_stb_o, 0);
      repeat (5) step();
      check("conflict_state", state_o, 3'd0);

      // asynchronous reset mid-TUNE
      atu_ack_raw_i = 1'b0;
      repeat (40) step();
      pulse_start();
      count_req(n);
      step();
      check("rst_mid_tune_up", tune_tx_req_o, 1);
      repeat (50) step();
      #2 rst = 1'b1;
      #1;
      check("arst_atu_req", atu_req_o, 0);
      check("arst_tune", tune_tx_req_o, 0);
      check("arst_busy", busy_o, 0);
      check("arst_result", result_o, 2'd0);
      check("arst_stb", result_stb_o, 0);
      step();
      step();
      atu_ack_raw_i = 1'b1;
      rst = 1'b0;
      repeat (10) step();
      check("arst_idle", state_o, 3'd0);
      run_nominal("nom2");
      repeat (5) step();

      // final report
      check("sb_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
